mem_port_arbiter: RTL and testbench

- Sits directly downstream of the CPU top.
- Merges the CPU's split instruction and data word-level memory ports into one word-level memory port that feeds the memory/cache subsystem.
- Serves one transaction at a time, grants round-robin, and registers both the forwarded request and the returned response.

---
 rtl/mem_port_arbiter_pkg.sv | 46 ++++
 rtl/mem_arb_select.sv | 32 +++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for mem_port_arbiter: FSM states, requester select and the request payload.
// Widths of the request payload are fixed here at 32-bit address / 32-bit data.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    INST_BUSY = 2'd1,
    DATA_BUSY = 2'd2,
    RESP      = 2'd3
  } arb_state_e;

  typedef enum logic {
    INST = 1'b0,
    DATA = 1'b1
  } req_sel_e;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [BE_W-1:0]   byte_enable;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  // A requester raising both read and write is treated as a write.
  function automatic mem_req_t make_req(
    input logic [ADDR_W-1:0] address,
    input logic              read,
    input logic              write,
    input logic [BE_W-1:0]   byte_enable,
    input logic [DATA_W-1:0] wdata
  );
    mem_req_t req;
    req.address     = address;
    req.read        = read & ~write;
    req.write       = write;
    req.byte_enable = byte_enable;
    req.wdata       = wdata;
    return req;
  endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Combinational grant decision between the instruction and data requesters.
// MEM_ARB_FIXED_PRIO_EN: data always wins a tie; otherwise round-robin on last_grant.
module mem_arb_select
  import mem_port_arbiter_pkg::*;
(
  input  logic     i_inst_pend,
  input  logic     i_data_pend,
  input  req_sel_e i_last_grant,
  output logic     o_grant_valid_c,
  output req_sel_e o_grant_sel_c
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic w_unused_last_grant;
  assign w_unused_last_grant = i_last_grant;
`endif

  always_comb begin
    o_grant_valid_c = i_inst_pend | i_data_pend;
    o_grant_sel_c   = INST;
    if (i_inst_pend && i_data_pend) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      o_grant_sel_c = DATA;
`else
      o_grant_sel_c = (i_last_grant == INST) ? DATA : INST;
`endif
    end else if (i_data_pend) begin
      o_grant_sel_c = DATA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Merges the CPU instruction and data word ports into one memory port, one transaction at a time.
// Optional build macro: MEM_ARB_FIXED_PRIO_EN (data wins every tie instead of round-robin).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   inst_mem_address,
  input  logic                    inst_mem_read,
  input  logic                    inst_mem_write,
  input  logic [DATA_WIDTH/8-1:0] inst_mem_byte_enable,
  input  logic [DATA_WIDTH-1:0]   inst_mem_wdata,
  output logic [DATA_WIDTH-1:0]   inst_mem_rdata,
  output logic                    inst_mem_resp,
  input  logic [ADDR_WIDTH-1:0]   data_mem_address,
  input  logic                    data_mem_read,
  input  logic                    data_mem_write,
  input  logic [DATA_WIDTH/8-1:0] data_mem_byte_enable,
  input  logic [DATA_WIDTH-1:0]   data_mem_wdata,
  output logic [DATA_WIDTH-1:0]   data_mem_rdata,
  output logic                    data_mem_resp,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_resp
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  arb_state_e            r_state, w_next_state;
  mem_req_t              r_req, w_next_req;
  req_sel_e              r_last_grant, w_next_last_grant;
  logic [DATA_WIDTH-1:0] r_inst_rdata, w_next_inst_rdata;
  logic [DATA_WIDTH-1:0] r_data_rdata, w_next_data_rdata;
  logic                  r_inst_resp, w_next_inst_resp;
  logic                  r_data_resp, w_next_data_resp;

  mem_req_t w_inst_req, w_data_req;
  logic     w_grant_valid;
  req_sel_e w_grant_sel;

  assign w_inst_req = make_req(ADDR_W'(inst_mem_address), inst_mem_read, inst_mem_write,
                               BE_W'(inst_mem_byte_enable), DATA_W'(inst_mem_wdata));
  assign w_data_req = make_req(ADDR_W'(data_mem_address), data_mem_read, data_mem_write,
                               BE_W'(data_mem_byte_enable), DATA_W'(data_mem_wdata));

  mem_arb_select u_select (
    .i_inst_pend     (inst_mem_read | inst_mem_write),
    .i_data_pend     (data_mem_read | data_mem_write),
    .i_last_grant    (r_last_grant),
    .o_grant_valid_c (w_grant_valid),
    .o_grant_sel_c   (w_grant_sel)
  );

  // Reset abandons any in-flight transaction without issuing a resp.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_req        <= '0;
      r_last_grant <= INST;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
      r_inst_resp  <= 1'b0;
      r_data_resp  <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_req        <= w_next_req;
      r_last_grant <= w_next_last_grant;
      r_inst_rdata <= w_next_inst_rdata;
      r_data_rdata <= w_next_data_rdata;
      r_inst_resp  <= w_next_inst_resp;
      r_data_resp  <= w_next_data_resp;
    end
  end

  // RESP never grants, so a request still held during its own resp cycle is not re-served.
  always_comb begin
    w_next_state      = r_state;
    w_next_req        = r_req;
    w_next_last_grant = r_last_grant;
    w_next_inst_rdata = r_inst_rdata;
    w_next_data_rdata = r_data_rdata;
    w_next_inst_resp  = 1'b0;
    w_next_data_resp  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_valid) begin
          w_next_last_grant = w_grant_sel;
          if (w_grant_sel == DATA) begin
            w_next_req   = w_data_req;
            w_next_state = DATA_BUSY;
          end else begin
            w_next_req   = w_inst_req;
            w_next_state = INST_BUSY;
          end
        end
      end
      INST_BUSY: begin
        if (mem_resp) begin
          w_next_req.read   = 1'b0;
          w_next_req.write  = 1'b0;
          w_next_inst_rdata = mem_rdata;
          w_next_inst_resp  = 1'b1;
          w_next_state      = RESP;
        end
      end
      DATA_BUSY: begin
        if (mem_resp) begin
          w_next_req.read   = 1'b0;
          w_next_req.write  = 1'b0;
          w_next_data_rdata = mem_rdata;
          w_next_data_resp  = 1'b1;
          w_next_state      = RESP;
        end
      end
      RESP: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign mem_address     = ADDR_WIDTH'(r_req.address);
  assign mem_read        = r_req.read;
  assign mem_write       = r_req.write;
  assign mem_byte_enable = BE_WIDTH'(r_req.byte_enable);
  assign mem_wdata       = DATA_WIDTH'(r_req.wdata);
  assign inst_mem_rdata  = r_inst_rdata;
  assign inst_mem_resp   = r_inst_resp;
  assign data_mem_rdata  = r_data_rdata;
  assign data_mem_resp   = r_data_resp;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; expectations follow MEM_ARB_FIXED_PRIO_EN.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_mem_address, data_mem_address, mem_address;
  logic        inst_mem_read, inst_mem_write, data_mem_read, data_mem_write;
  logic [3:0]  inst_mem_byte_enable, data_mem_byte_enable, mem_byte_enable;
  logic [31:0] inst_mem_wdata, data_mem_wdata, mem_wdata;
  logic [31:0] inst_mem_rdata, data_mem_rdata, mem_rdata;
  logic        inst_mem_resp, data_mem_resp;
  logic        mem_read, mem_write, mem_resp;

  int n_vec = 0;
  int n_err = 0;

  mem_port_arbiter dut (
    .clk                  (clk),
    .rst                  (rst),
    .inst_mem_address     (inst_mem_address),
    .inst_mem_read        (inst_mem_read),
    .inst_mem_write       (inst_mem_write),
    .inst_mem_byte_enable (inst_mem_byte_enable),
    .inst_mem_wdata       (inst_mem_wdata),
    .inst_mem_rdata       (inst_mem_rdata),
    .inst_mem_resp        (inst_mem_resp),
    .data_mem_address     (data_mem_address),
    .data_mem_read        (data_mem_read),
    .data_mem_write       (data_mem_write),
    .data_mem_byte_enable (data_mem_byte_enable),
    .data_mem_wdata       (data_mem_wdata),
    .data_mem_rdata       (data_mem_rdata),
    .data_mem_resp        (data_mem_resp),
    .mem_address          (mem_address),
    .mem_read             (mem_read),
    .mem_write            (mem_write),
    .mem_byte_enable      (mem_byte_enable),
    .mem_wdata            (mem_wdata),
    .mem_rdata            (mem_rdata),
    .mem_resp             (mem_resp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    inst_mem_address = '0; inst_mem_read = 0; inst_mem_write = 0;
    inst_mem_byte_enable = '0; inst_mem_wdata = '0;
    data_mem_address = '0; data_mem_read = 0; data_mem_write = 0;
    data_mem_byte_enable = '0; data_mem_wdata = '0;
    mem_rdata = '0; mem_resp = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".mem_addr"},  mem_address, 0);
    chk({tag, ".mem_rd"},    mem_read, 0);
    chk({tag, ".mem_wr"},    mem_write, 0);
    chk({tag, ".mem_be"},    mem_byte_enable, 0);
    chk({tag, ".mem_wd"},    mem_wdata, 0);
    chk({tag, ".i_rdata"},   inst_mem_rdata, 0);
    chk({tag, ".d_rdata"},   data_mem_rdata, 0);
    chk({tag, ".i_resp"},    inst_mem_resp, 0);
    chk({tag, ".d_resp"},    data_mem_resp, 0);
  endtask

  logic exp_data;

  initial begin
    idle_inputs();
    do_reset();
    chk_all_zero("rst");

    // 1: single instruction read, memory answers two cycles after the op appears
    inst_mem_address = 32'h0000_0060; inst_mem_read = 1; inst_mem_byte_enable = 4'hF;
    tick();
    chk("t1.mem_rd", mem_read, 1);
    chk("t1.mem_wr", mem_write, 0);
    chk("t1.addr", mem_address, 32'h60);
    tick();
    chk("t1.hold_rd", mem_read, 1);
    chk("t1.no_iresp", inst_mem_resp, 0);
    mem_resp = 1; mem_rdata = 32'h0051_3093;
    tick();
    mem_resp = 0; mem_rdata = 32'h0;
    chk("t1.iresp", inst_mem_resp, 1);
    chk("t1.irdata", inst_mem_rdata, 32'h0051_3093);
    chk("t1.no_dresp", data_mem_resp, 0);
    chk("t1.rd_clr", mem_read, 0);
    tick();
    inst_mem_read = 0;
    chk("t1.iresp_end", inst_mem_resp, 0);
    chk("t1.no_regrant", mem_read, 0);
    chk("t1.rdata_hold", inst_mem_rdata, 32'h0051_3093);
    chk("t1.no_dresp2", data_mem_resp, 0);

    // 2: tie straight after reset goes to data, then the next tie resolves by policy
    do_reset();
    inst_mem_address = 32'h100; inst_mem_read = 1; inst_mem_byte_enable = 4'hF;
    data_mem_address = 32'h2000; data_mem_write = 1; data_mem_byte_enable = 4'hF;
    data_mem_wdata = 32'hDEAD_BEEF;
    tick();
    chk("t2.mem_wr", mem_write, 1);
    chk("t2.mem_rd", mem_read, 0);
    chk("t2.addr", mem_address, 32'h2000);
    chk("t2.wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("t2.be", mem_byte_enable, 4'hF);
    mem_resp = 1; mem_rdata = 32'h0000_1234;
    tick();
    mem_resp = 0;
    chk("t2.dresp", data_mem_resp, 1);
    chk("t2.no_iresp", inst_mem_resp, 0);
    chk("t2.wr_clr", mem_write, 0);
    tick();
    chk("t2.resp_no_grant_rd", mem_read, 0);
    chk("t2.resp_no_grant_wr", mem_write, 0);
    tick();
`ifdef MEM_ARB_FIXED_PRIO_EN
    exp_data = 1'b1;
`else
    exp_data = 1'b0;
`endif
    chk("t2.tie2_wr", mem_write, exp_data);
    chk("t2.tie2_rd", mem_read, !exp_data);
    chk("t2.tie2_addr", mem_address, exp_data ? 32'h2000 : 32'h100);
    mem_resp = 1; mem_rdata = 32'hCAFE_0001;
    tick();
    mem_resp = 0;
    chk("t2.tie2_iresp", inst_mem_resp, !exp_data);
    chk("t2.tie2_dresp", data_mem_resp, exp_data);
    if (!exp_data) chk("t2.irdata", inst_mem_rdata, 32'hCAFE_0001);
    idle_inputs();
    tick();

    // 3: read and write together on the data port is forwarded as a write
    data_mem_address = 32'h40; data_mem_read = 1; data_mem_write = 1;
    data_mem_byte_enable = 4'h3; data_mem_wdata = 32'h0000_00AA;
    tick();
    chk("t3.mem_wr", mem_write, 1);
    chk("t3.mem_rd", mem_read, 0);
    chk("t3.be", mem_byte_enable, 4'h3);
    chk("t3.addr", mem_address, 32'h40);
    mem_resp = 1;
    tick();
    mem_resp = 0;
    chk("t3.dresp", data_mem_resp, 1);
    idle_inputs();
    tick();

    // 4: a mem_resp with nothing outstanding is ignored
    mem_resp = 1; mem_rdata = 32'h5555_5555;
    tick();
    mem_resp = 0;
    chk("t4.no_iresp", inst_mem_resp, 0);
    chk("t4.no_dresp", data_mem_resp, 0);
    tick();
    chk("t4.no_iresp2", inst_mem_resp, 0);
    chk("t4.no_dresp2", data_mem_resp, 0);
    inst_mem_address = 32'h0000_0070; inst_mem_read = 1;
    tick();
    chk("t4.still_idle", mem_read, 1);
    chk("t4.addr", mem_address, 32'h70);
    mem_resp = 1; mem_rdata = 32'h0000_0777;
    tick();
    mem_resp = 0;
    chk("t4.iresp", inst_mem_resp, 1);
    chk("t4.irdata", inst_mem_rdata, 32'h0000_0777);
    idle_inputs();
    tick();

    // 5: reset in DATA_BUSY clears everything at once and drops the transaction
    data_mem_address = 32'h3000; data_mem_write = 1; data_mem_byte_enable = 4'hC;
    data_mem_wdata = 32'h1357_9BDF;
    tick();
    chk("t5.busy_wr", mem_write, 1);
    #2 rst = 1'b0;
    #1;
    chk_all_zero("t5.async");
    data_mem_write = 0;
    inst_mem_address = 32'h80; inst_mem_read = 1;
    tick();
    rst = 1'b1;
    tick();
    chk("t5.regrant_rd", mem_read, 1);
    chk("t5.regrant_addr", mem_address, 32'h80);
    chk("t5.no_dresp", data_mem_resp, 0);
    mem_resp = 1; mem_rdata = 32'h0000_0888;
    tick();
    mem_resp = 0;
    chk("t5.iresp", inst_mem_resp, 1);
    chk("t5.no_dresp2", data_mem_resp, 0);
    idle_inputs();
    tick();

    // 6: four back-to-back ties from reset
    do_reset();
    inst_mem_address = 32'h500; inst_mem_read = 1;
    data_mem_address = 32'h600; data_mem_write = 1; data_mem_byte_enable = 4'hF;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp_data = 1'b1;
`else
      exp_data = (i % 2 == 0);
`endif
      tick();
      chk($sformatf("t6.g%0d_wr", i), mem_write, exp_data);
      chk($sformatf("t6.g%0d_rd", i), mem_read, !exp_data);
      mem_resp = 1;
      tick();
      mem_resp = 0;
      chk($sformatf("t6.g%0d_dresp", i), data_mem_resp, exp_data);
      chk($sformatf("t6.g%0d_iresp", i), inst_mem_resp, !exp_data);
      tick();
    end
    idle_inputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
